// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder
// Brief    : Ping-pong buffer that turns bit-reversed FFT output frames into
//            natural-order frames on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module fft_reorder #(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [FLOAT_PRECISION-1:0] di_re,
    input  logic [FLOAT_PRECISION-1:0] di_im,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [FLOAT_PRECISION-1:0] do_re,
    output logic [FLOAT_PRECISION-1:0] do_im,
    output logic [logn-1:0]            do_idx,
    output logic                       out_last,
    output logic                       overflow
);

    localparam int              c_n        = 1 << logn;
    localparam logic [logn-1:0] c_last_idx = '1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    function automatic logic [logn-1:0] bitrev(input logic [logn-1:0] a);
        logic [logn-1:0] r;
        r = '0;
        for (int i = 0; i < logn; i++) begin
            r[i] = a[logn-1-i];
        end
        return r;
    endfunction

    // Both banks share one array; the bank pointer is the address MSB.
    logic [FLOAT_PRECISION-1:0] r_mem_re [0:2*c_n-1];
    logic [FLOAT_PRECISION-1:0] r_mem_im [0:2*c_n-1];

    logic [logn-1:0]            r_wcnt;
    logic                       r_wbank;
    logic [1:0]                 r_full;
    logic                       r_overflow;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [logn-1:0]            r_rcnt;
    logic                       r_rbank;

    logic                       r_out_valid;
    logic [FLOAT_PRECISION-1:0] r_do_re;
    logic [FLOAT_PRECISION-1:0] r_do_im;
    logic [logn-1:0]            r_do_idx;
    logic                       r_out_last;

    logic                       w_wr_full;
    logic                       w_accept;
    logic                       w_wr_last;
    logic [logn:0]              w_waddr;
    logic [logn:0]              w_raddr;
    logic                       w_load_en;
    logic                       w_rd_avail;
    logic                       w_load;
    logic                       w_rd_last;
    logic [1:0]                 w_full_set;
    logic [1:0]                 w_full_clr;

    assign w_wr_full  = r_full[r_wbank];
    assign w_accept   = in_valid & ~w_wr_full;
    assign w_wr_last  = w_accept & (r_wcnt == c_last_idx);
    assign w_waddr    = {r_wbank, bitrev(r_wcnt)};
    assign w_raddr    = {r_rbank, r_rcnt};

    // Loading straight from IDLE keeps the one-cycle fill-to-valid latency
    // and lets back-to-back frames stream without a bubble.
    assign w_load_en  = ~r_out_valid | out_ready;
    assign w_rd_avail = (r_state == S_STREAM) | r_full[r_rbank];
    assign w_load     = w_load_en & w_rd_avail;
    assign w_rd_last  = w_load & (r_rcnt == c_last_idx);

    assign w_full_set = {w_wr_last & r_wbank, w_wr_last & ~r_wbank};
    assign w_full_clr = {w_rd_last & r_rbank, w_rd_last & ~r_rbank};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_re[w_waddr] <= di_re;
            r_mem_im[w_waddr] <= di_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt     <= '0;
            r_wbank    <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_accept) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_wr_last) begin
                r_wbank <= ~r_wbank;
            end
            if (in_valid && w_wr_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rbank] && !w_rd_last) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_rd_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt      <= '0;
            r_rbank     <= 1'b0;
            r_out_valid <= 1'b0;
            r_do_re     <= '0;
            r_do_im     <= '0;
            r_do_idx    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rcnt      <= r_rcnt + 1'b1;
                r_out_valid <= 1'b1;
                r_do_re     <= r_mem_re[w_raddr];
                r_do_im     <= r_mem_im[w_raddr];
                r_do_idx    <= r_rcnt;
                r_out_last  <= (r_rcnt == c_last_idx);
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
            if (w_rd_last) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign do_re     = r_do_re;
    assign do_im     = r_do_im;
    assign do_idx    = r_do_idx;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_reorder
// Brief    : Directed self-checking bench for fft_reorder with N = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_reorder;

    localparam int W    = 64;
    localparam int LOGN = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    di_re;
    logic [W-1:0]    di_im;
    logic            out_ready;
    logic            out_valid;
    logic [W-1:0]    do_re;
    logic [W-1:0]    do_im;
    logic [LOGN-1:0] do_idx;
    logic            out_last;
    logic            overflow;

    fft_reorder #(
        .FLOAT_PRECISION(W),
        .logn           (LOGN)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .di_re    (di_re),
        .di_im    (di_im),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_idx   (do_idx),
        .out_last (out_last),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int k_next = 0;
    int run_len = 0;
    int max_run = 0;
    int c_rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [W-1:0]    q_re   [$];
    logic [W-1:0]    q_im   [$];
    logic [LOGN-1:0] q_idx  [$];
    logic            q_last [$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_re.push_back(do_re);
            q_im.push_back(do_im);
            q_idx.push_back(do_idx);
            q_last.push_back(out_last);
        end
        run_len = out_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic q_clear();
        q_re.delete();
        q_im.delete();
        q_idx.delete();
        q_last.delete();
    endtask

    // Drives n consecutive samples starting just after a rising edge.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            di_re    = W'(k_next);
            di_im    = ~W'(k_next);
            k_next++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_n(input string tag, input int n);
        int cyc;
        cyc = 0;
        while (q_re.size() < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_count"}, W'(q_re.size()), W'(n));
    endtask

    task automatic check_frame(input string tag, input int base, input int start);
        for (int i = 0; i < 8; i++) begin
            if (start + i < q_re.size()) begin
                chk($sformatf("%s_re[%0d]", tag, i), q_re[start+i], W'(base + c_rev[i]));
                chk($sformatf("%s_im[%0d]", tag, i), q_im[start+i], ~W'(base + c_rev[i]));
                chk($sformatf("%s_idx[%0d]", tag, i), W'(q_idx[start+i]), W'(i));
                chk($sformatf("%s_last[%0d]", tag, i), W'(q_last[start+i]), W'(i == 7));
            end
        end
    endtask

    initial begin
        int base_a;
        int base_b;
        int base_c;
        int base_d1;
        int base_d2;
        int base_e;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        di_re     = '0;
        di_im     = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", W'(out_valid), 0);
        chk("rst_re", do_re, 0);
        chk("rst_im", do_im, 0);
        chk("rst_idx", W'(do_idx), 0);
        chk("rst_last", W'(out_last), 0);
        chk("rst_ovf", W'(overflow), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, latency and ordering
        q_clear();
        base_a = k_next;
        send(8);
        chk("lat_pre", W'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_rise", W'(out_valid), 1);
        chk("lat_idx", W'(do_idx), 0);
        wait_n("a", 8);
        check_frame("a", base_a, 0);
        repeat (3) @(posedge clk);
        #1;

        // Four back-to-back frames
        q_clear();
        max_run = 0;
        base_b  = k_next;
        send(32);
        wait_n("b", 32);
        check_frame("b0", base_b, 0);
        check_frame("b1", base_b + 8, 8);
        check_frame("b2", base_b + 16, 16);
        check_frame("b3", base_b + 24, 24);
        chk("b_contig", W'(max_run), 32);
        chk("b_ovf", W'(overflow), 0);
        repeat (3) @(posedge clk);
        #1;

        // Five-cycle stall mid-frame
        q_clear();
        base_c = k_next;
        send(8);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("c_hold_valid%0d", i), W'(out_valid), 1);
            chk($sformatf("c_hold_idx%0d", i), W'(do_idx), 2);
            chk($sformatf("c_hold_re%0d", i), do_re, W'(base_c + 2));
        end
        chk("c_hold_cnt", W'(q_re.size()), 2);
        out_ready = 1'b1;
        wait_n("c", 8);
        check_frame("c", base_c, 0);
        repeat (3) @(posedge clk);
        #1;

        // Three frames against a stalled sink: third is dropped
        q_clear();
        out_ready = 1'b0;
        base_d1   = k_next;
        base_d2   = k_next + 8;
        send(24);
        @(posedge clk);
        #1;
        chk("d_ovf", W'(overflow), 1);
        chk("d_valid", W'(out_valid), 1);
        chk("d_idx", W'(do_idx), 0);
        out_ready = 1'b1;
        wait_n("d", 16);
        check_frame("d1", base_d1, 0);
        check_frame("d2", base_d2, 8);
        repeat (10) @(posedge clk);
        #1;
        chk("d_no_extra", W'(q_re.size()), 16);
        chk("d_idle", W'(out_valid), 0);
        chk("d_ovf_sticky", W'(overflow), 1);

        // Reset after the fifth sample of a frame
        send(5);
        rst_n = 1'b0;
        #1;
        chk("e_valid", W'(out_valid), 0);
        chk("e_re", do_re, 0);
        chk("e_im", do_im, 0);
        chk("e_idx", W'(do_idx), 0);
        chk("e_last", W'(out_last), 0);
        chk("e_ovf", W'(overflow), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_clear();
        base_e = k_next;
        send(8);
        wait_n("e", 8);
        check_frame("e", base_e, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("e_no_extra", W'(q_re.size()), 8);
        chk("e_ovf_end", W'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
